fetch_ctrl: RTL and testbench

//  Instruction-fetch sequencer in front of the instruction memory (async-read, combinational).

---
 rtl/fetch_ctrl.sv | 114 +++++++++++
 tb/tb_fetch_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives an async-read instruction memory
// and registers each fetched word into a valid/ready stage for decode.
module fetch_ctrl #(
  parameter int unsigned               ADDR_W  = 6,
  parameter int unsigned               INST_W  = 8,
  parameter logic [INST_W-1:0]         HALT_OP = 8'hFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INST_W-1:0] imem_data,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic [INST_W-1:0]   r_inst;
  logic [ADDR_W-1:0]   r_inst_pc;
  logic                r_valid;
  logic                w_valid_nxt;
  logic                r_done;
  logic                w_done_nxt;
  logic                w_capture;
  logic                w_load;

  assign w_load = !r_valid || inst_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_valid_nxt = r_valid;
    w_done_nxt  = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_pc_nxt    = start_addr;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        // A redirect squashes the held word even if decode is accepting it this cycle.
        if (branch_taken) begin
          w_pc_nxt    = branch_target;
          w_valid_nxt = 1'b0;
        end else if (w_load) begin
          w_capture   = 1'b1;
          w_valid_nxt = 1'b1;
          if (imem_data == HALT_OP) begin
            w_state_nxt = HALTED;
          end else begin
            w_pc_nxt = r_pc + ADDR_W'(1);
          end
        end
      end
      HALTED: begin
        if (r_valid && inst_ready) begin
          w_valid_nxt = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_pc      <= '0;
      r_inst    <= '0;
      r_inst_pc <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_valid <= w_valid_nxt;
      r_done  <= w_done_nxt;
      if (w_capture) begin
        r_inst    <= imem_data;
        r_inst_pc <= r_pc;
      end
    end
  end

  assign imem_addr  = r_pc;
  assign inst_out   = r_inst;
  assign inst_pc    = r_inst_pc;
  assign inst_valid = r_valid;
  assign done       = r_done;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed vector table, hand-written corner
// sequences and a randomized run against a program-level reference model.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       reset, start, inst_ready, branch_taken;
  logic [5:0] start_addr, branch_target, imem_addr, inst_pc;
  logic [7:0] imem_data, inst_out;
  logic       inst_valid, busy, done;

  logic [7:0] mem [64];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;
  assign imem_data = mem[imem_addr];

  fetch_ctrl #(.ADDR_W(6), .INST_W(8), .HALT_OP(8'hFF)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .imem_addr(imem_addr), .imem_data(imem_data), .inst_out(inst_out),
    .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .busy(busy), .done(done)
  );

  typedef struct {
    logic       rst, st;
    logic [5:0] sa;
    logic       rdy, br;
    logic [5:0] tgt;
    logic       v;
    logic [7:0] o;
    logic [5:0] p;
    logic       b, d;
    logic [5:0] a;
  } vec_t;

  vec_t vt[22];

  function automatic vec_t mk(logic rst, logic st, logic [5:0] sa, logic rdy, logic br,
                              logic [5:0] tgt, logic v, logic [7:0] o, logic [5:0] p,
                              logic b, logic d, logic [5:0] a);
    vec_t r;
    r.rst = rst; r.st = st; r.sa = sa; r.rdy = rdy; r.br = br; r.tgt = tgt;
    r.v = v; r.o = o; r.p = p; r.b = b; r.d = d; r.a = a;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic v, input logic [7:0] o,
                           input logic [5:0] p, input logic b, input logic d,
                           input logic [5:0] a);
    check({tag, ".valid"}, 32'(inst_valid), 32'(v));
    if (v) begin
      check({tag, ".inst"}, 32'(inst_out), 32'(o));
      check({tag, ".pc"},   32'(inst_pc),  32'(p));
    end
    check({tag, ".busy"}, 32'(busy),      32'(b));
    check({tag, ".done"}, 32'(done),      32'(d));
    check({tag, ".addr"}, 32'(imem_addr), 32'(a));
  endtask

  task automatic drive(input logic rst, input logic st, input logic [5:0] sa,
                       input logic rdy, input logic br, input logic [5:0] tgt);
    reset = rst; start = st; start_addr = sa;
    inst_ready = rdy; branch_taken = br; branch_target = tgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: program-level view of the fetch unit.
  logic       m_running, m_halt_pending, m_slot_full, m_done;
  logic [5:0] m_pc, m_slot_pc;
  logic [7:0] m_slot;

  task automatic model_step();
    logic [7:0] word;
    m_done = 1'b0;
    if (reset) begin
      m_running = 0; m_halt_pending = 0; m_slot_full = 0;
      m_pc = 0; m_slot = 0; m_slot_pc = 0;
    end else if (!m_running) begin
      if (start) begin
        m_pc = start_addr;
        m_running = 1;
      end
    end else if (!m_halt_pending) begin
      if (branch_taken) begin
        m_pc = branch_target;
        m_slot_full = 0;
      end else if (!m_slot_full || inst_ready) begin
        word = mem[m_pc];
        m_slot = word;
        m_slot_pc = m_pc;
        m_slot_full = 1;
        if (word == 8'hFF) m_halt_pending = 1;
        else m_pc = 6'((int'(m_pc) + 1) % 64);
      end
    end else if (m_slot_full && inst_ready) begin
      m_slot_full = 0;
      m_done = 1;
      m_running = 0;
      m_halt_pending = 0;
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'hFF;
    mem[10] = 8'hAA; mem[11] = 8'hFF;

    //        rst st sa rdy br tgt   v  out    pc  busy done addr
    vt[0]  = mk(1, 1, 0, 1, 0, 0,    0, 8'h00, 0,  0, 0, 0);
    vt[1]  = mk(1, 1, 0, 1, 0, 0,    0, 8'h00, 0,  0, 0, 0);
    vt[2]  = mk(0, 1, 0, 1, 0, 0,    0, 8'h00, 0,  1, 0, 0);
    vt[3]  = mk(0, 0, 0, 1, 0, 0,    1, 8'h11, 0,  1, 0, 1);
    vt[4]  = mk(0, 0, 0, 1, 0, 0,    1, 8'h22, 1,  1, 0, 2);
    vt[5]  = mk(0, 0, 0, 1, 0, 0,    1, 8'h33, 2,  1, 0, 3);
    vt[6]  = mk(0, 0, 0, 1, 0, 0,    1, 8'hFF, 3,  1, 0, 3);
    vt[7]  = mk(0, 0, 0, 1, 0, 0,    0, 8'hFF, 3,  0, 1, 3);
    vt[8]  = mk(0, 0, 0, 1, 0, 0,    0, 8'hFF, 3,  0, 0, 3);
    vt[9]  = mk(0, 1, 0, 0, 0, 0,    0, 8'hFF, 3,  1, 0, 0);
    vt[10] = mk(0, 0, 0, 0, 0, 0,    1, 8'h11, 0,  1, 0, 1);
    vt[11] = mk(0, 0, 0, 1, 0, 0,    1, 8'h22, 1,  1, 0, 2);
    vt[12] = mk(0, 0, 0, 0, 0, 0,    1, 8'h22, 1,  1, 0, 2);
    vt[13] = mk(0, 0, 0, 0, 0, 0,    1, 8'h22, 1,  1, 0, 2);
    vt[14] = mk(0, 0, 0, 0, 0, 0,    1, 8'h22, 1,  1, 0, 2);
    vt[15] = mk(0, 0, 0, 1, 0, 0,    1, 8'h33, 2,  1, 0, 3);
    vt[16] = mk(0, 0, 0, 1, 1, 10,   0, 8'h33, 2,  1, 0, 10);
    vt[17] = mk(0, 0, 0, 1, 0, 0,    1, 8'hAA, 10, 1, 0, 11);
    vt[18] = mk(0, 0, 0, 1, 0, 0,    1, 8'hFF, 11, 1, 0, 11);
    vt[19] = mk(0, 1, 5, 0, 1, 5,    1, 8'hFF, 11, 1, 0, 11);
    vt[20] = mk(0, 0, 0, 1, 0, 0,    0, 8'hFF, 11, 0, 1, 11);
    vt[21] = mk(0, 0, 0, 1, 0, 0,    0, 8'hFF, 11, 0, 0, 11);

    for (int i = 0; i < 22; i++) begin
      drive(vt[i].rst, vt[i].st, vt[i].sa, vt[i].rdy, vt[i].br, vt[i].tgt);
      step();
      check_all($sformatf("vec%0d", i), vt[i].v, vt[i].o, vt[i].p, vt[i].b, vt[i].d, vt[i].a);
    end

    // PC wrap from the top of memory into a HALT at address 0.
    mem[63] = 8'h05; mem[0] = 8'hFF;
    drive(0, 1, 63, 1, 0, 0); step(); check_all("wrap.start", 0, 0, 0, 1, 0, 63);
    drive(0, 0, 0, 1, 0, 0);  step(); check_all("wrap.w0", 1, 8'h05, 63, 1, 0, 0);
    step();                           check_all("wrap.w1", 1, 8'hFF, 0, 1, 0, 0);
    step();                           check_all("wrap.done", 0, 0, 0, 0, 1, 0);
    mem[0] = 8'h11;

    // Start ignored mid-fetch, then reset during a stall, then a clean restart.
    drive(0, 1, 0, 1, 0, 0);  step();
    drive(0, 0, 0, 1, 0, 0);  step(); check_all("mid.w0", 1, 8'h11, 0, 1, 0, 1);
    drive(0, 1, 40, 1, 0, 0); step(); check_all("mid.ign", 1, 8'h22, 1, 1, 0, 2);
    drive(0, 0, 0, 0, 0, 0);  step(); check_all("mid.stall", 1, 8'h22, 1, 1, 0, 2);
    drive(1, 0, 0, 0, 0, 0);  step(); check_all("mid.rst", 0, 0, 0, 0, 0, 0);
    check("mid.rst.inst", 32'(inst_out), 32'h0);
    drive(0, 0, 0, 1, 0, 0);  step(); check_all("mid.idle", 0, 0, 0, 0, 0, 0);
    drive(0, 1, 2, 1, 0, 0);  step(); check_all("mid.restart", 0, 0, 0, 1, 0, 2);
    drive(0, 0, 0, 1, 0, 0);  step(); check_all("mid.r0", 1, 8'h33, 2, 1, 0, 3);

    // Randomized run against the reference model.
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
    drive(1, 0, 0, 0, 0, 0);
    model_step();
    step();
    for (int c = 0; c < 3000; c++) begin
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0, 6'($urandom_range(0, 63)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0, 6'($urandom_range(0, 63)));
      model_step();
      step();
      check_all($sformatf("rnd%0d", c), m_slot_full, m_slot, m_slot_pc, m_running, m_done, m_pc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
